spi_reg_ctrl: RTL

- SPI slave command controller that configures the sprite/SVGA register file from the external SPI pins.
- Sits between the chip-level SPI pins and the sprite register block inside top.
- Decodes one opcode byte followed by a burst of data bytes with an auto-incrementing address.
- Issues single-cycle register write/read strobes in the clk domain.

---
 rtl/spi_reg_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave command controller driving register write/read strobes in the clk domain.
// Optional read-back path enabled by defining SPI_READBACK_EN; otherwise read opcodes are discarded.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_DISCARD
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_cs;

    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_cs_rise;
    logic                   r_cs_fall;
    logic                   r_mosi_q;

    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic [7:0]             r_byte;
    logic                   r_byte_done;
    logic                   r_cs_rise_q;
    logic                   r_cs_fall_q;
    logic                   r_fall_q;

    state_t                 r_state;

`ifdef SPI_READBACK_EN
    logic [7:0]             r_tx;
    logic                   r_re_d;
`else
    logic                   w_unused_rdata;
    assign w_unused_rdata = ^reg_rdata;
`endif

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];

    // Input synchronisers, reset to the idle bus levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
        end
    end

    // Registered edge pulses on the synchronised SPI signals
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_mosi_q    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
            r_rise      <= w_sclk & ~r_sclk_prev;
            r_fall      <= ~w_sclk & r_sclk_prev;
            r_cs_rise   <= w_cs & ~r_cs_prev;
            r_cs_fall   <= ~w_cs & r_cs_prev;
            r_mosi_q    <= w_mosi;
            busy        <= ~w_cs;
        end
    end

    // Byte assembly; a cs edge clears the counter and suppresses any completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_byte      <= 8'd0;
            r_byte_done <= 1'b0;
            r_cs_rise_q <= 1'b0;
            r_cs_fall_q <= 1'b0;
            r_fall_q    <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_cs_rise_q <= r_cs_rise;
            r_cs_fall_q <= r_cs_fall;
            r_fall_q    <= r_fall;
            if (r_cs_rise || r_cs_fall) begin
                r_bit_cnt <= 3'd0;
            end else if (r_rise && busy) begin
                r_shift   <= {r_shift[5:0], r_mosi_q};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_done <= 1'b1;
                    r_byte      <= {r_shift, r_mosi_q};
                end
            end
        end
    end

    // Command FSM with registered strobes, address and MISO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            spi_miso  <= 1'b0;
`ifdef SPI_READBACK_EN
            r_tx      <= 8'd0;
            r_re_d    <= 1'b0;
`endif
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
`ifdef SPI_READBACK_EN
            r_re_d <= reg_re;
`endif
            if (reg_we) begin
                reg_addr <= reg_addr + ADDR_W'(1);
            end
            if (r_cs_rise_q) begin
                r_state  <= S_IDLE;
                spi_miso <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_cs_fall_q) begin
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (r_byte_done) begin
                            reg_addr <= r_byte[ADDR_W-1:0];
                            if (r_byte[7]) begin
`ifdef SPI_READBACK_EN
                                reg_re  <= 1'b1;
                                r_state <= S_RDATA;
`else
                                r_state <= S_DISCARD;
`endif
                            end else begin
                                r_state <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (r_byte_done) begin
                            reg_wdata <= r_byte;
                            reg_we    <= 1'b1;
                        end
                    end
`ifdef SPI_READBACK_EN
                    S_RDATA: begin
                        // Falls with the counter at 0 close the previous byte and must not shift
                        if (r_re_d) begin
                            r_tx     <= {reg_rdata[6:0], 1'b0};
                            spi_miso <= reg_rdata[7];
                        end else if (r_fall_q && (r_bit_cnt != 3'd0)) begin
                            spi_miso <= r_tx[7];
                            r_tx     <= {r_tx[6:0], 1'b0};
                        end
                        if (r_byte_done) begin
                            reg_addr <= reg_addr + ADDR_W'(1);
                            reg_re   <= 1'b1;
                        end
                    end
`endif
                    S_DISCARD: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
